// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - SRAM-like slave: in-order response queue in front of a synchronous RAM
// Requests launch to the RAM on accept; each queue entry waits out its own latency before returning.
module sram_like_slave #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic [2:0]  delay_cfg,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0] FULL_C = (PW + 1)'(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0] vld_q, wr_flag_q, cap_q;
    logic [2:0]             cnt_q  [QUEUE_DEPTH];
    logic [31:0]            data_q [QUEUE_DEPTH];
    logic [PW-1:0]          rd_ptr_q, wr_ptr_q, cap_idx_q;
    logic [PW:0]            count_q, count_d;
    logic                   cap_pend_q;

    logic        accept, pop, head_cap;
    logic [31:0] head_data;
    logic        unused_size;

    assign unused_size = ^size;

    // A pop in the same cycle does not free a slot: count_q only.
    assign addr_ok = req && (count_q < FULL_C) && resetn;
    assign accept  = req && addr_ok;

    assign ram_en    = accept;
    assign ram_wen   = (accept && wr) ? wstrb : 4'h0;
    assign ram_addr  = addr;
    assign ram_wdata = wdata;

    // The entry accepted last cycle counts as captured now: its RAM data is on ram_rdata.
    assign head_cap  = cap_q[rd_ptr_q] || (cap_pend_q && (cap_idx_q == rd_ptr_q));
    assign head_data = cap_q[rd_ptr_q]     ? data_q[rd_ptr_q] :
                       wr_flag_q[rd_ptr_q] ? 32'h0 : ram_rdata;

    assign data_ok = resetn && (count_q != '0) && vld_q[rd_ptr_q] && head_cap
                     && (cnt_q[rd_ptr_q] == 3'd0);
    assign pop     = data_ok;
    assign rdata   = data_ok ? head_data : 32'h0;

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (pop && !accept) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q      <= '0;
            cap_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (vld_q[i] && (cnt_q[i] != 3'd0)) begin
                    cnt_q[i] <= cnt_q[i] - 3'd1;
                end
            end
            if (cap_pend_q) begin
                data_q[cap_idx_q] <= wr_flag_q[cap_idx_q] ? 32'h0 : ram_rdata;
                cap_q[cap_idx_q]  <= 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PW'(1);
            end
            if (accept) begin
                vld_q[wr_ptr_q]     <= 1'b1;
                wr_flag_q[wr_ptr_q] <= wr;
                cnt_q[wr_ptr_q]     <= delay_cfg;
                cap_q[wr_ptr_q]     <= 1'b0;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            cap_pend_q <= accept;
            cap_idx_q  <= wr_ptr_q;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - scoreboard bench for sram_like_slave with a behavioural synchronous RAM
module tb_sram_like_slave;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [2:0]  delay_cfg;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          idle_rdata_bad = 0;
    int          last_exp = 0;

    sram_like_slave #(.QUEUE_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .delay_cfg(delay_cfg), .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM; contents reload whenever reset is held.
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hD000_0000 + 32'(i);
            mem[8'h40] <= 32'h1122_3344;
            mem[8'h80] <= 32'h0000_0000;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    always @(negedge clk) begin
        if (data_ok) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_data_ok cycle=%0d rdata=%h required no response", cyc, rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                if (rdata !== e.data) begin
                    mismatched++;
                    $display("FAIL rdata cycle=%0d got=%h expected=%h", cyc, rdata, e.data);
                end
                compared++;
                if (cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL response_cycle got=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end else if (rdata !== 32'h0) begin
            idle_rdata_bad++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic check_quiet_outputs(input string name);
        check({name, "_addr_ok"}, 32'(addr_ok), 32'h0);
        check({name, "_data_ok"}, 32'(data_ok), 32'h0);
        check({name, "_rdata"}, rdata, 32'h0);
        check({name, "_ram_en"}, 32'(ram_en), 32'h0);
        check({name, "_ram_wen"}, 32'(ram_wen), 32'h0);
    endtask

    // Entered and left at posedge+1; req is left high for back-to-back issue.
    task automatic issue(input logic w, input logic [3:0] strb, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] dly, input logic [31:0] expd,
                         output int t_acc, output int stalls);
        exp_t e;
        t_acc  = -1;
        stalls = 0;
        req = 1'b1; wr = w; wstrb = strb; addr = a; wdata = d; delay_cfg = dly;
        size = 2'd2;
        for (int tries = 0; tries < 40; tries++) begin
            @(negedge clk);
            if (addr_ok) begin
                t_acc = cyc;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (t_acc < 0) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout addr=%h got=no accept expected=accept within 40 cycles", a);
            req = 1'b0;
        end else begin
            @(posedge clk); #1;
            e.data = expd;
            e.cyc  = (t_acc + 1 + int'(dly) > last_exp + 1) ? t_acc + 1 + int'(dly) : last_exp + 1;
            last_exp = e.cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0; wr = 1'b0; wstrb = 4'h0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_outstanding"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int t, st, t0, t5;
        resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd0; wstrb = 4'hF;
        addr = 32'h0; wdata = 32'h0; delay_cfg = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(3);

        // single read
        issue(1'b0, 4'h0, 32'h100, 32'h0, 3'd0, 32'h1122_3344, t, st);
        idle(1);
        drain("single_read");

        // write then read, partial strobes
        issue(1'b1, 4'b0011, 32'h200, 32'hAABB_CCDD, 3'd0, 32'h0, t, st);
        issue(1'b0, 4'h0, 32'h200, 32'h0, 3'd0, 32'h0000_CCDD, t, st);
        idle(1);
        drain("write_read");

        // ordering: ready younger waits behind slow head
        issue(1'b0, 4'h0, 32'h100, 32'h0, 3'd5, 32'h1122_3344, t, st);
        issue(1'b0, 4'h0, 32'h0, 32'h0, 3'd0, 32'hD000_0000, t, st);
        idle(1);
        drain("ordering");

        // full queue back-pressure
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'h0, 32'(i * 4), 32'h0, 3'd7, 32'hD000_0000 + 32'(i), t, st);
            if (i == 0) t0 = t;
        end
        issue(1'b0, 4'h0, 32'h10, 32'h0, 3'd0, 32'hD000_0004, t5, st);
        check("full_stall_cycles", 32'(st), 32'd5);
        check("full_fifth_accept", 32'(t5 - t0), 32'd9);
        idle(1);
        drain("full");

        // pointer wrap with a back-to-back stream
        for (int i = 0; i < 10; i++)
            issue(1'b0, 4'h0, 32'(i * 4), 32'h0, 3'd0, 32'hD000_0000 + 32'(i), t, st);
        idle(1);
        drain("wrap");

        // reset with three entries pending
        for (int i = 0; i < 3; i++)
            issue(1'b0, 4'h0, 32'h14 + 32'(i * 4), 32'h0, 3'd7, 32'hD000_0005 + 32'(i), t, st);
        idle(1);
        resetn = 1'b0; req = 1'b1;
        @(negedge clk);
        check_quiet_outputs("mid_reset");
        @(posedge clk); #1;
        resetn = 1'b1; req = 1'b0;
        sb.delete();
        last_exp = 0;
        idle(15);
        issue(1'b0, 4'h0, 32'h20, 32'h0, 3'd0, 32'hD000_0008, t, st);
        idle(1);
        drain("post_reset");

        check("idle_rdata_nonzero", 32'(idle_rdata_bad), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
